// File: rtl/wisc_pipe_pkg.sv
// wisc_pipe_pkg: shared pipeline-control types and constants.
// rev 1.0
`default_nettype none

package wisc_pipe_pkg;
  localparam int REG_ADDR_W = 4;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    IWAIT = 2'd1,
    DWAIT = 2'd2,
    HALT  = 2'd3
  } state_e;
endpackage

`default_nettype wire

// File: rtl/sat_counter.sv
// sat_counter: up-counter that sticks at all-ones instead of wrapping.
// rev 1.0
`default_nettype none

module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl: hazard/miss/halt stall and flush control with performance counters.
// rev 1.0
`default_nettype none

module pipe_stall_ctrl
  import wisc_pipe_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] ifid_rs,
  input  logic [REG_ADDR_W-1:0] ifid_rt,
  input  logic                  ifid_use_rs,
  input  logic                  ifid_use_rt,
  input  logic                  idex_mem_read,
  input  logic [REG_ADDR_W-1:0] idex_dst,
  input  logic                  imiss,
  input  logic                  dmiss,
  input  logic                  hlt_wb,
  output logic                  pc_stall,
  output logic                  ifid_stall,
  output logic                  idex_stall,
  output logic                  exmem_stall,
  output logic                  memwb_stall,
  output logic                  idex_flush,
  output logic                  halted,
  output logic [CNT_W-1:0]      stall_cycles,
  output logic [CNT_W-1:0]      imiss_cnt,
  output logic [CNT_W-1:0]      dmiss_cnt
);

  state_e state;
  logic   load_use;
  logic   halt_now;
  logic   enter_iwait;
  logic   enter_dwait;
  logic   stall_inc;

  assign load_use = idex_mem_read && (idex_dst != '0) &&
                    ((ifid_use_rs && (ifid_rs == idex_dst)) ||
                     (ifid_use_rt && (ifid_rt == idex_dst)));

  assign halt_now = (state == HALT) || hlt_wb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
    end else if (state != HALT) begin
      if (hlt_wb)      state <= HALT;
      else if (dmiss)  state <= DWAIT;
      else if (imiss)  state <= IWAIT;
      else             state <= RUN;
    end
  end

  // Outputs react to inputs in the same cycle; only HALT needs remembered state.
  always_comb begin
    pc_stall    = 1'b0;
    ifid_stall  = 1'b0;
    idex_stall  = 1'b0;
    exmem_stall = 1'b0;
    memwb_stall = 1'b0;
    idex_flush  = 1'b0;
    halted      = halt_now;
    if (halt_now || dmiss) begin
      pc_stall    = 1'b1;
      ifid_stall  = 1'b1;
      idex_stall  = 1'b1;
      exmem_stall = 1'b1;
      memwb_stall = 1'b1;
    end else if (imiss || load_use) begin
      pc_stall    = 1'b1;
      ifid_stall  = 1'b1;
      idex_flush  = 1'b1;
    end
  end

  // Miss counters count state entries, so a long miss is one event.
  assign enter_iwait = ((state == RUN) || (state == DWAIT)) && !hlt_wb && !dmiss && imiss;
  assign enter_dwait = ((state == RUN) || (state == IWAIT)) && !hlt_wb && dmiss;
  assign stall_inc   = pc_stall && (state != HALT);

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall_inc),
    .count (stall_cycles)
  );

  sat_counter #(.W(CNT_W)) u_imiss_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (enter_iwait),
    .count (imiss_cnt)
  );

  sat_counter #(.W(CNT_W)) u_dmiss_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (enter_dwait),
    .count (dmiss_cnt)
  );

endmodule

`default_nettype wire

// File: tb/tb_pipe_stall_ctrl.sv
// tb_pipe_stall_ctrl: directed checks of stall/flush priority, FSM counters and reset.
// rev 1.0
`default_nettype none

module tb_pipe_stall_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rst4_n = 1'b0;
  logic [3:0] ifid_rs = '0, ifid_rt = '0, idex_dst = '0;
  logic       ifid_use_rs = 1'b0, ifid_use_rt = 1'b0, idex_mem_read = 1'b0;
  logic       imiss = 1'b0, dmiss = 1'b0, hlt_wb = 1'b0;

  logic        pc_stall, ifid_stall, idex_stall, exmem_stall, memwb_stall, idex_flush, halted;
  logic [15:0] stall_cycles, imiss_cnt, dmiss_cnt;
  logic        pc4, ifid4, idex4, exmem4, memwb4, flush4, halted4;
  logic [3:0]  stall4, imiss4, dmiss4;

  int total = 0;
  int passed = 0;

  // Packed view: {pc, ifid, idex, exmem, memwb, flush, halted}
  wire [6:0] outs  = {pc_stall, ifid_stall, idex_stall, exmem_stall, memwb_stall, idex_flush, halted};
  wire [6:0] outs4 = {pc4, ifid4, idex4, exmem4, memwb4, flush4, halted4};

  localparam logic [6:0] O_NONE = 7'b0000000;
  localparam logic [6:0] O_FLSH = 7'b1100010;
  localparam logic [6:0] O_ALL  = 7'b1111100;
  localparam logic [6:0] O_HALT = 7'b1111101;

  always #5 clk = ~clk;

  pipe_stall_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_use_rs(ifid_use_rs), .ifid_use_rt(ifid_use_rt),
    .idex_mem_read(idex_mem_read), .idex_dst(idex_dst),
    .imiss(imiss), .dmiss(dmiss), .hlt_wb(hlt_wb),
    .pc_stall(pc_stall), .ifid_stall(ifid_stall), .idex_stall(idex_stall),
    .exmem_stall(exmem_stall), .memwb_stall(memwb_stall),
    .idex_flush(idex_flush), .halted(halted),
    .stall_cycles(stall_cycles), .imiss_cnt(imiss_cnt), .dmiss_cnt(dmiss_cnt)
  );

  pipe_stall_ctrl #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst4_n),
    .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_use_rs(ifid_use_rs), .ifid_use_rt(ifid_use_rt),
    .idex_mem_read(idex_mem_read), .idex_dst(idex_dst),
    .imiss(imiss), .dmiss(dmiss), .hlt_wb(hlt_wb),
    .pc_stall(pc4), .ifid_stall(ifid4), .idex_stall(idex4),
    .exmem_stall(exmem4), .memwb_stall(memwb4),
    .idex_flush(flush4), .halted(halted4),
    .stall_cycles(stall4), .imiss_cnt(imiss4), .dmiss_cnt(dmiss4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    #12;
    chk("reset_outs", 32'(outs), 32'(O_NONE));
    chk("reset_stall_cnt", 32'(stall_cycles), 0);
    chk("reset_imiss_cnt", 32'(imiss_cnt), 0);
    chk("reset_dmiss_cnt", 32'(dmiss_cnt), 0);
    rst_n = 1'b1;
    cyc();
    chk("idle_outs", 32'(outs), 32'(O_NONE));

    // Load-use on rs: one-cycle bubble
    idex_mem_read = 1'b1; idex_dst = 4'd3; ifid_rs = 4'd3; ifid_use_rs = 1'b1;
    #1 chk("lu_rs_outs", 32'(outs), 32'(O_FLSH));
    cyc();
    idex_mem_read = 1'b0;
    #1 chk("lu_rs_release", 32'(outs), 32'(O_NONE));
    chk("lu_rs_stall_cnt", 32'(stall_cycles), 1);

    // Destination r0 never hazards; rt path and unused-field masking
    idex_mem_read = 1'b1; idex_dst = 4'd0; ifid_rs = 4'd0;
    #1 chk("lu_r0_outs", 32'(outs), 32'(O_NONE));
    ifid_use_rs = 1'b0; ifid_rt = 4'd5; ifid_use_rt = 1'b1; idex_dst = 4'd5;
    #1 chk("lu_rt_outs", 32'(outs), 32'(O_FLSH));
    ifid_use_rt = 1'b0;
    #1 chk("lu_rt_unused", 32'(outs), 32'(O_NONE));
    idex_mem_read = 1'b0; ifid_rt = 4'd0; idex_dst = 4'd0;

    // I-cache miss for five cycles
    imiss = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1 chk("imiss_outs", 32'(outs), 32'(O_FLSH));
      cyc();
    end
    chk("imiss_cnt_1", 32'(imiss_cnt), 1);
    chk("imiss_stall_cnt", 32'(stall_cycles), 6);
    imiss = 1'b0;
    #1 chk("imiss_release", 32'(outs), 32'(O_NONE));
    cyc();

    // D-cache miss overlapping a load-use hazard
    dmiss = 1'b1; idex_mem_read = 1'b1; idex_dst = 4'd3; ifid_rs = 4'd3; ifid_use_rs = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("dmiss_lu_outs", 32'(outs), 32'(O_ALL));
      cyc();
    end
    chk("dmiss_cnt_1", 32'(dmiss_cnt), 1);
    chk("dmiss_stall_cnt", 32'(stall_cycles), 9);
    dmiss = 1'b0; idex_mem_read = 1'b0; imiss = 1'b1;
    #1 chk("d2i_outs", 32'(outs), 32'(O_FLSH));
    cyc();
    chk("d2i_imiss_cnt", 32'(imiss_cnt), 2);
    cyc();
    chk("iwait_hold_cnt", 32'(imiss_cnt), 2);
    imiss = 1'b0; dmiss = 1'b1;
    cyc();
    chk("i2d_dmiss_cnt", 32'(dmiss_cnt), 2);
    chk("i2d_stall_cnt", 32'(stall_cycles), 12);
    dmiss = 1'b0;
    cyc();
    chk("back_run_outs", 32'(outs), 32'(O_NONE));
    chk("back_run_stall_cnt", 32'(stall_cycles), 12);

    // Halt is sticky until reset
    hlt_wb = 1'b1;
    #1 chk("hlt_outs", 32'(outs), 32'(O_HALT));
    cyc();
    hlt_wb = 1'b0;
    #1 chk("halt_sticky", 32'(outs), 32'(O_HALT));
    imiss = 1'b1; cyc(); dmiss = 1'b1; cyc(); cyc();
    chk("halt_outs_misses", 32'(outs), 32'(O_HALT));
    chk("halt_stall_cnt", 32'(stall_cycles), 13);
    chk("halt_imiss_cnt", 32'(imiss_cnt), 2);
    chk("halt_dmiss_cnt", 32'(dmiss_cnt), 2);
    imiss = 1'b0; dmiss = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk("async_rst_outs", 32'(outs), 32'(O_NONE));
    chk("async_rst_stall_cnt", 32'(stall_cycles), 0);
    chk("async_rst_dmiss_cnt", 32'(dmiss_cnt), 0);
    cyc();
    rst_n = 1'b1;
    cyc();
    chk("post_halt_run", 32'(outs), 32'(O_NONE));

    // Reset in the middle of a miss
    imiss = 1'b1; cyc(); cyc();
    chk("midmiss_imiss_cnt", 32'(imiss_cnt), 1);
    imiss = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk("midmiss_rst_imiss", 32'(imiss_cnt), 0);
    chk("midmiss_rst_outs", 32'(outs), 32'(O_NONE));
    cyc();
    rst_n = 1'b1; rst4_n = 1'b1;
    cyc();

    // Saturation at CNT_W=4 over 20 stall cycles
    imiss = 1'b1;
    #1 chk("sat_outs4", 32'(outs4), 32'(O_FLSH));
    for (int i = 0; i < 20; i++) cyc();
    chk("sat_stall4", 32'(stall4), 15);
    chk("sat_imiss4", 32'(imiss4), 1);
    chk("sat_dmiss4", 32'(dmiss4), 0);
    chk("wide_stall_cnt", 32'(stall_cycles), 20);
    imiss = 1'b0;
    cyc();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
